// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display-side outputs of the stopwatch sequencer.
// The master side drives the buttons and observes the display buses; the
// slave side is the sequencer itself. state_dbg exposes the FSM state.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic [3:0] num_1;
    logic [3:0] num_2;
    logic [3:0] num_3;
    logic [3:0] num_4;
    logic       scan_tick;
    logic       running;
    logic       ovf;
    logic [1:0] state_dbg;

    modport master (
        output btn_ss, btn_lap,
        input  num_1, num_2, num_3, num_4, scan_tick, running, ovf, state_dbg
    );

    modport slave (
        input  btn_ss, btn_lap,
        output num_1, num_2, num_3, num_4, scan_tick, running, ovf, state_dbg
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: 10 ms prescaler, four-digit BCD count (SS.hh),
// start/stop and lap/clear button FSM, lap freeze, display scan pulse.
// Buttons are level inputs; a press is a rising edge of the sampled level.
// All outputs are registered and reflect the state after the same edge that
// caused a change.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_ctrl_if.slave   sw
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [15:0]   CNT_MAX  = 16'h9999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [SW-1:0] scan_cnt;
    logic [15:0]   cnt, cnt_n;      // {tens, ones, tenths, hundredths}
    logic [15:0]   lap, lap_n;
    logic [15:0]   cnt_inc;
    logic [15:0]   disp_q;
    logic          ovf_q, ovf_n;
    logic          running_q;
    logic          scan_tick_q;
    logic          btn_ss_q, btn_lap_q;
    logic          press_ss, press_lap;
    logic          tick;

    // Rising-edge detect; start/stop wins over lap/clear in the same cycle.
    always_comb begin
        press_ss  = sw.btn_ss & ~btn_ss_q;
        press_lap = sw.btn_lap & ~btn_lap_q & ~press_ss;
        tick      = ((state == S_RUN) || (state == S_LAP)) && (presc == TICK_MAX);
    end

    // Cascaded BCD increment of the count; only used below the 99.99 ceiling.
    always_comb begin
        cnt_inc = cnt;
        if (cnt[3:0] == 4'd9) begin
            cnt_inc[3:0] = 4'd0;
            if (cnt[7:4] == 4'd9) begin
                cnt_inc[7:4] = 4'd0;
                if (cnt[11:8] == 4'd9) begin
                    cnt_inc[11:8]  = 4'd0;
                    cnt_inc[15:12] = cnt[15:12] + 4'd1;
                end else begin
                    cnt_inc[11:8] = cnt[11:8] + 4'd1;
                end
            end else begin
                cnt_inc[7:4] = cnt[7:4] + 4'd1;
            end
        end else begin
            cnt_inc[3:0] = cnt[3:0] + 4'd1;
        end
    end

    // Next-state logic; an overflow tick overrides any button in that cycle.
    always_comb begin
        state_n = state;
        presc_n = presc;
        cnt_n   = cnt;
        lap_n   = lap;
        ovf_n   = ovf_q;
        case (state)
            S_IDLE: begin
                presc_n = '0;
                cnt_n   = '0;
                if (press_ss) state_n = S_RUN;
            end
            S_RUN, S_LAP: begin
                presc_n = tick ? '0 : presc + PW'(1);
                if (tick && (cnt == CNT_MAX)) begin
                    ovf_n   = 1'b1;
                    state_n = S_PAUSE;
                end else begin
                    if (tick) cnt_n = cnt_inc;
                    if (press_ss) begin
                        state_n = S_PAUSE;
                    end else if (press_lap) begin
                        if (state == S_RUN) begin
                            state_n = S_LAP;
                            lap_n   = cnt_n;
                        end else begin
                            state_n = S_RUN;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (press_ss) begin
                    if (!ovf_q) state_n = S_RUN;
                end else if (press_lap) begin
                    state_n = S_IDLE;
                    presc_n = '0;
                    cnt_n   = '0;
                    lap_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, count and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            presc     <= '0;
            cnt       <= '0;
            lap       <= '0;
            ovf_q     <= 1'b0;
            disp_q    <= '0;
            running_q <= 1'b0;
            btn_ss_q  <= 1'b1;
            btn_lap_q <= 1'b1;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            cnt       <= cnt_n;
            lap       <= lap_n;
            ovf_q     <= ovf_n;
            disp_q    <= (state_n == S_LAP) ? lap_n : cnt_n;
            running_q <= (state_n == S_RUN) || (state_n == S_LAP);
            btn_ss_q  <= sw.btn_ss;
            btn_lap_q <= sw.btn_lap;
        end
    end

    // Free-running display scan divider, independent of the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= '0;
            scan_tick_q <= 1'b0;
        end else begin
            scan_tick_q <= (scan_cnt == SCAN_MAX);
            scan_cnt    <= (scan_cnt == SCAN_MAX) ? '0 : scan_cnt + SW'(1);
        end
    end

    assign sw.num_1     = disp_q[15:12];
    assign sw.num_2     = disp_q[11:8];
    assign sw.num_3     = disp_q[7:4];
    assign sw.num_4     = disp_q[3:0];
    assign sw.running   = running_q;
    assign sw.ovf       = ovf_q;
    assign sw.scan_tick = scan_tick_q;
    assign sw.state_dbg = state;
endmodule
